// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit serializer.
// Frame state encoding, payload width and default baud divisor.
package uart_tx_serializer_pkg;

    localparam int UART_DATA_W           = 8;
    localparam int UART_BAUD_DIV_DEFAULT = 434;

    // TX_PARITY is kept even when parity is not built so the encoding never shifts.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_e;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte-send request and serial line between the UART control FSM and the serializer.
// master = control FSM side, slave = serializer side.
interface uart_tx_serializer_if;
    import uart_tx_serializer_pkg::*;

    logic                   send;
    logic [UART_DATA_W-1:0] data;
    logic                   tx;
    logic                   Tx_ready;

    modport master (
        output send,
        output data,
        input  tx,
        input  Tx_ready
    );

    modport slave (
        input  send,
        input  data,
        output tx,
        output Tx_ready
    );

endinterface

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// Bit-time counter: one-cycle tick when the count reaches BAUD_DIV-1, then wraps.
// Synchronous clear restarts the bit time; counting only advances while enabled.
module uart_tx_serializer_baud_tick_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter; tx/Tx_ready go low the cycle after send is sampled in IDLE.
// send is ignored while busy. Build with UART_TX_PARITY_EN for an even-parity bit (8E1).
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_serializer_if.slave  bus
);

    uart_tx_state_e         state;
    logic [UART_DATA_W-1:0] shreg;
    logic [2:0]             idx;
    logic                   tx_q;
    logic                   rdy_q;
    logic                   tick;
    logic                   start;
    logic                   busy;
`ifdef UART_TX_PARITY_EN
    logic                   par_q;
`endif

    assign start = (state == TX_IDLE) && bus.send;
    assign busy  = (state != TX_IDLE);

    uart_tx_serializer_baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (busy),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TX_IDLE;
            tx_q  <= 1'b1;
            rdy_q <= 1'b1;
            shreg <= '0;
            idx   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            case (state)
                TX_IDLE: begin
                    if (bus.send) begin
                        shreg <= bus.data;
                        idx   <= '0;
                        tx_q  <= 1'b0;
                        rdy_q <= 1'b0;
                        state <= TX_START;
`ifdef UART_TX_PARITY_EN
                        par_q <= even_parity(bus.data);
`endif
                    end else begin
                        tx_q  <= 1'b1;
                        rdy_q <= 1'b1;
                    end
                end

                TX_START: begin
                    if (tick) begin
                        tx_q  <= shreg[0];
                        state <= TX_DATA;
                    end
                end

                TX_DATA: begin
                    if (tick) begin
                        // idx wraps 7 -> 0 on the last bit, leaving it clean for the next frame.
                        shreg <= {1'b0, shreg[UART_DATA_W-1:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q  <= par_q;
                            state <= TX_PARITY;
`else
                            tx_q  <= 1'b1;
                            state <= TX_STOP;
`endif
                        end else begin
                            tx_q <= shreg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (tick) begin
                        tx_q  <= 1'b1;
                        state <= TX_STOP;
                    end
                end
`endif

                TX_STOP: begin
                    if (tick) begin
                        tx_q  <= 1'b1;
                        rdy_q <= 1'b1;
                        state <= TX_IDLE;
                    end
                end

                default: begin
                    tx_q  <= 1'b1;
                    rdy_q <= 1'b1;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.tx       = tx_q;
    assign bus.Tx_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed + random bench for uart_tx_serializer at BAUD_DIV=4 with a serial-line decoder.
module tb_uart_tx_serializer;
    import uart_tx_serializer_pkg::*;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BD;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_serializer_if u_if();

    uart_tx_serializer #(
        .BAUD_DIV (BD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mon_q[$];
    logic       mon_stop_q[$];
`ifdef UART_TX_PARITY_EN
    logic       mon_par_q[$];
`endif
    logic [7:0] exp_q[$];

    // Line-level frame: bit 0 start, 1..8 data LSB first, optional even parity, stop last.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
        if (NBITS == 11) f[9] = ^b;
        f[NBITS-1] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial decoder: samples mid-bit, drops any frame cut short by reset.
    initial begin
        logic [7:0] d;
        logic       s;
        logic       p;
        logic       ab;
        int         bi;
        d = '0; s = 1'b0; p = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && u_if.tx === 1'b0) begin
                ab = 1'b0;
                for (int c = 1; c <= (NBITS - 1) * BD + 2; c++) begin
                    @(negedge clk);
                    if (reset) begin
                        ab = 1'b1;
                        break;
                    end
                    if (c % BD == 2) begin
                        bi = c / BD;
                        if (bi >= 1 && bi <= 8) d[bi-1] = u_if.tx;
                        else if (bi == NBITS - 1) s = u_if.tx;
                        else p = u_if.tx;
                    end
                end
                if (!ab) begin
                    mon_q.push_back(d);
                    mon_stop_q.push_back(s);
`ifdef UART_TX_PARITY_EN
                    mon_par_q.push_back(p);
`endif
                end
            end
        end
    end

    task automatic check_queues(input string tag);
        chk({tag, "_count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_byte"}, (i < mon_q.size()) ? {24'd0, mon_q[i]} : 32'hDEAD, {24'd0, exp_q[i]});
            chk({tag, "_stop"}, (i < mon_stop_q.size()) ? {31'd0, mon_stop_q[i]} : 32'hDEAD, 32'd1);
        end
        mon_q.delete();
        mon_stop_q.delete();
        exp_q.delete();
    endtask

    // One-cycle send pulse, then cycle-by-cycle comparison of tx against the model frame.
    task automatic pulse_frame(input logic [7:0] b, input string tag);
        logic [10:0] f;
        int          bad_tx;
        int          bad_rdy;
        f       = frame_bits(b);
        bad_tx  = 0;
        bad_rdy = 0;
        u_if.send = 1'b1;
        u_if.data = b;
        exp_q.push_back(b);
        @(negedge clk);
        u_if.send = 1'b0;
        u_if.data = 8'($urandom);
        chk({tag, "_rdy_fall"}, u_if.Tx_ready, 0);
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (u_if.tx !== f[c/BD]) bad_tx++;
            if (u_if.Tx_ready !== 1'b0) bad_rdy++;
        end
        chk({tag, "_tx_bad_cycles"}, bad_tx, 0);
        chk({tag, "_rdy_low_bad_cycles"}, bad_rdy, 0);
        @(negedge clk);
        chk({tag, "_rdy_rise"}, u_if.Tx_ready, 1);
        chk({tag, "_tx_idle"}, u_if.tx, 1);
    endtask

    // Count cycles with Tx_ready low from the current cycle until it rises (bounded).
    task automatic count_low(output int low);
        low = 0;
        while (u_if.Tx_ready !== 1'b1 && low < 200) begin
            low++;
            @(negedge clk);
        end
    endtask

    // Control-FSM style: hold send until Tx_ready falls, then wait for it to rise.
    task automatic handshake_send(input logic [7:0] b, input string tag);
        int waitc;
        int low;
        u_if.send = 1'b1;
        u_if.data = b;
        exp_q.push_back(b);
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (u_if.Tx_ready !== 1'b0 && waitc < 20);
        chk({tag, "_fall_latency"}, waitc, 1);
        u_if.send = 1'b0;
        u_if.data = 8'($urandom);
        count_low(low);
        chk({tag, "_frame_len"}, low, FRAME);
    endtask

    initial begin
        int bad;
        int low;
        int waitc;
        logic [7:0] rb;

        u_if.send = 1'b0;
        u_if.data = 8'h00;

        // 1: reset held for 3 cycles, then quiet line.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_tx", u_if.tx, 1);
            chk("reset_rdy", u_if.Tx_ready, 1);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.Tx_ready !== 1'b1) bad++;
        end
        chk("idle_quiet_bad_cycles", bad, 0);

        // 2: single pulse of 0xFE.
        pulse_frame(8'hFE, "pulse_FE");
        check_queues("pulse_FE_mon");

        // 3: handshake sequence.
        handshake_send(8'hFE, "hs_FE");
        handshake_send(8'h05, "hs_05");
        handshake_send(8'hEF, "hs_EF");
        repeat (2) @(negedge clk);
        check_queues("hs_seq");

        // 4: send held high -> back-to-back frames with one idle cycle.
        u_if.data = 8'h55;
        u_if.send = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h33);
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (u_if.Tx_ready !== 1'b0 && waitc < 20);
        chk("b2b_first_fall", waitc, 1);
        count_low(low);
        chk("b2b_first_len", low, FRAME);
        u_if.data = 8'h33;
        @(negedge clk);
        chk("b2b_gap_one_cycle", u_if.Tx_ready, 0);
        u_if.send = 1'b0;
        u_if.data = 8'h00;
        count_low(low);
        chk("b2b_second_len", low, FRAME);
        @(negedge clk);
        chk("b2b_stays_idle", u_if.Tx_ready, 1);
        repeat (2) @(negedge clk);
        check_queues("b2b");

        // 5: data changes two cycles into the frame.
        u_if.data = 8'hA5;
        u_if.send = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        u_if.send = 1'b0;
        @(negedge clk);
        u_if.data = 8'h00;
        count_low(low);
        chk("data_change_len", low, FRAME - 1);
        repeat (2) @(negedge clk);
        check_queues("data_change");

        // 6: reset during data bit 3 of 0x3C, then a clean 0x3C frame.
        u_if.data = 8'h3C;
        u_if.send = 1'b1;
        @(negedge clk);
        u_if.send = 1'b0;
        repeat (17) @(negedge clk);
        chk("abort_bit3_on_line", u_if.tx, 1);
        chk("abort_busy", u_if.Tx_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_tx", u_if.tx, 1);
        chk("abort_rdy", u_if.Tx_ready, 1);
        reset = 1'b0;
        bad = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.Tx_ready !== 1'b1) bad++;
        end
        chk("abort_no_resume_bad_cycles", bad, 0);
        pulse_frame(8'h3C, "after_abort");
        repeat (2) @(negedge clk);
        check_queues("after_abort");

        // send and reset together: reset wins.
        reset = 1'b1;
        u_if.send = 1'b1;
        u_if.data = 8'h81;
        @(negedge clk);
        chk("send_with_reset_rdy", u_if.Tx_ready, 1);
        chk("send_with_reset_tx", u_if.tx, 1);
        u_if.send = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("send_with_reset_idle", u_if.Tx_ready, 1);

`ifdef UART_TX_PARITY_EN
        handshake_send(8'h07, "parity_07");
        repeat (2) @(negedge clk);
        chk("parity_07_bit", (mon_par_q.size() > 0) ? {31'd0, mon_par_q[0]} : 32'hDEAD, 1);
        mon_par_q.delete();
        check_queues("parity_07");
`endif

        // Random bytes through both request styles.
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            if (i % 2 == 0) pulse_frame(rb, "rand_pulse");
            else handshake_send(rb, "rand_hs");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_queues("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
